// File: rtl/cnt_disp_scan_if.sv
// Bundle between the cnt200 counter and its display stage.
// The master side drives the count and terminal-count flag.
// The slave side (the display stage) drives the 7-segment, digit-enable and status outputs.
interface cnt_disp_scan_if;
  logic [3:0] QH;
  logic [3:0] QL;
  logic       C;
  logic [6:0] Seg;
  logic [2:0] Dig;
  logic       Busy;
  logic       Err;
  logic       Wrap;

  modport master (
    output QH, QL, C,
    input  Seg, Dig, Busy, Err, Wrap
  );

  modport slave (
    input  QH, QL, C,
    output Seg, Dig, Busy, Err, Wrap
  );
endinterface

// File: rtl/cnt_disp_scan.sv
// Display stage for the cnt200 counter.
// The stage samples the 8-bit count and converts it to BCD with a sequential
// shift-add-3 engine. It then scans three multiplexed 7-segment digits with
// leading-zero blanking, and toggles Wrap on each rising edge of the terminal-count flag.
// SCAN_DIV is the number of clocks each digit stays lit. It must be at least 2.
module cnt_disp_scan #(
  parameter int SCAN_DIV = 1000
) (
  input logic            Clk,
  input logic            MR,
  cnt_disp_scan_if.slave io
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  sample;
  logic [7:0]  bin_sr;
  logic [3:0]  work_h;
  logic [3:0]  work_t;
  logic [3:0]  work_u;
  logic [2:0]  shift_cnt;
  logic [3:0]  disp_h;
  logic [3:0]  disp_t;
  logic [3:0]  disp_u;
  logic        busy;
  logic        err;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig_idx;
  logic [6:0]    seg_q;
  logic [2:0]    dig_q;

  logic        c_prev;
  logic        wrap_q;

  logic [7:0]  count_in;
  logic [3:0]  adj_h;
  logic [3:0]  adj_t;
  logic [3:0]  adj_u;
  logic [19:0] dd_cat;
  logic [19:0] dd_next;

  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [2:0]  cur_dig;

  assign count_in = {io.QH, io.QL};

  // Add-3 correction applied to a BCD work digit before each shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    add3 = (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Decode a BCD digit to active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  // One double-dabble step: correct the digits, then shift the whole 20-bit word left.
  always_comb begin
    adj_h   = add3(work_h);
    adj_t   = add3(work_t);
    adj_u   = add3(work_u);
    dd_cat  = {adj_h, adj_t, adj_u, bin_sr};
    dd_next = dd_cat << 1;
  end

  // Conversion FSM.
  // The display registers change only in DONE, so they never hold a partial result.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      state     <= S_IDLE;
      sample    <= 8'd0;
      bin_sr    <= 8'd0;
      work_h    <= 4'd0;
      work_t    <= 4'd0;
      work_u    <= 4'd0;
      shift_cnt <= 3'd0;
      disp_h    <= 4'd0;
      disp_t    <= 4'd0;
      disp_u    <= 4'd0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count_in != sample) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          sample    <= count_in;
          bin_sr    <= count_in;
          work_h    <= 4'd0;
          work_t    <= 4'd0;
          work_u    <= 4'd0;
          shift_cnt <= 3'd0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          {work_h, work_t, work_u, bin_sr} <= dd_next;
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          disp_h <= work_h;
          disp_t <= work_t;
          disp_u <= work_u;
          err    <= (sample > 8'd199);
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Scan timing: each digit stays lit for SCAN_DIV clocks, cycling units, tens, hundreds.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : (dig_idx + 2'd1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Select the digit for the current scan position and apply leading-zero blanking.
  always_comb begin
    cur_digit = disp_u;
    cur_blank = 1'b0;
    cur_dig   = 3'b110;
    case (dig_idx)
      2'd0: begin
        cur_digit = disp_u;
        cur_blank = 1'b0;
        cur_dig   = 3'b110;
      end
      2'd1: begin
        cur_digit = disp_t;
        cur_blank = (disp_h == 4'd0) && (disp_t == 4'd0);
        cur_dig   = 3'b101;
      end
      2'd2: begin
        cur_digit = disp_h;
        cur_blank = (disp_h == 4'd0);
        cur_dig   = 3'b011;
      end
      default: begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
        cur_dig   = 3'b111;
      end
    endcase
  end

  // Register Seg and Dig together so both switch on the same edge and the display shows no ghosting.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      seg_q <= 7'h00;
      dig_q <= 3'b111;
    end else begin
      seg_q <= cur_blank ? 7'h00 : seg_of(cur_digit);
      dig_q <= cur_dig;
    end
  end

  // Toggle Wrap once per rising edge of the terminal-count flag.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      c_prev <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      c_prev <= io.C;
      if (io.C && !c_prev) begin
        wrap_q <= ~wrap_q;
      end
    end
  end

  assign io.Seg  = seg_q;
  assign io.Dig  = dig_q;
  assign io.Busy = busy;
  assign io.Err  = err;
  assign io.Wrap = wrap_q;

endmodule
